// File: rtl/pipe_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : pipe_id_stage
// Purpose  : MIPS instruction-decode stage: register file, writeback bypass,
//            load-use stall detection and the registered ID/EX payload.
// Revision : 1.0
// ============================================================================

module pipe_id_stage #(
  parameter int WIDTH = 32,
  parameter int NREG  = 32
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     in_valid,
  input  logic [31:0]              Ins,
  input  logic                     flush,
  input  logic                     wb_we,
  input  logic [$clog2(NREG)-1:0]  wb_adr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic                     stall,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_rdata1,
  output logic [WIDTH-1:0]         out_rdata2,
  output logic [WIDTH-1:0]         out_ed,
  output logic [$clog2(NREG)-1:0]  out_wadr,
  output logic                     out_we,
  output logic                     out_memread,
  output logic [5:0]               out_op
);

  localparam int AW = $clog2(NREG);

  localparam logic [5:0] c_op_rtype = 6'b000000;
  localparam logic [5:0] c_op_j     = 6'b000010;
  localparam logic [5:0] c_op_jal   = 6'b000011;
  localparam logic [5:0] c_op_beq   = 6'b000100;
  localparam logic [5:0] c_op_bne   = 6'b000101;
  localparam logic [5:0] c_op_andi  = 6'b001100;
  localparam logic [5:0] c_op_ori   = 6'b001101;
  localparam logic [5:0] c_op_xori  = 6'b001110;
  localparam logic [5:0] c_op_lw    = 6'b100011;
  localparam logic [5:0] c_op_sw    = 6'b101011;

  logic [WIDTH-1:0] regs_q [NREG];

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] rdata1_q,  rdata1_d;
  logic [WIDTH-1:0] rdata2_q,  rdata2_d;
  logic [WIDTH-1:0] ed_q,      ed_d;
  logic [AW-1:0]    wadr_q,    wadr_d;
  logic             we_q,      we_d;
  logic             memread_q, memread_d;
  logic [5:0]       op_q,      op_d;

  logic [5:0]       w_op;
  logic [AW-1:0]    w_rs, w_rt, w_rd, w_dest;
  logic [15:0]      w_imm;
  logic             w_zext, w_we, w_memread, w_wb_ok;
  logic [WIDTH-1:0] w_ed, w_rdata1, w_rdata2;

  assign w_op  = Ins[31:26];
  assign w_rs  = Ins[21 +: AW];
  assign w_rt  = Ins[16 +: AW];
  assign w_rd  = Ins[11 +: AW];
  assign w_imm = Ins[15:0];

  assign w_wb_ok = wb_we && (wb_adr != '0);

  always_comb begin
    w_zext = (w_op == c_op_andi) || (w_op == c_op_ori) || (w_op == c_op_xori);
    w_ed   = w_zext ? {{(WIDTH-16){1'b0}}, w_imm} : {{(WIDTH-16){w_imm[15]}}, w_imm};

    if (w_op == c_op_jal)        w_dest = AW'(NREG-1);
    else if (w_op == c_op_rtype) w_dest = w_rd;
    else                         w_dest = w_rt;

    // A destination of r0 can never be written, so never advertise a write.
    w_we = !((w_op == c_op_beq) || (w_op == c_op_bne) ||
             (w_op == c_op_j)   || (w_op == c_op_sw)) && (w_dest != '0);
    w_memread = (w_op == c_op_lw);

    if (w_rs == '0)                          w_rdata1 = '0;
    else if (w_wb_ok && (wb_adr == w_rs))    w_rdata1 = wb_data;
    else                                     w_rdata1 = regs_q[w_rs];

    if (w_rt == '0)                          w_rdata2 = '0;
    else if (w_wb_ok && (wb_adr == w_rt))    w_rdata2 = wb_data;
    else                                     w_rdata2 = regs_q[w_rt];
  end

  assign stall = in_valid & valid_q & memread_q & (wadr_q != '0) &
                 ((wadr_q == w_rs) | (wadr_q == w_rt));

  // Flush and stall both insert an all-zero bubble; flush simply wins.
  always_comb begin
    valid_d   = 1'b0;
    rdata1_d  = '0;
    rdata2_d  = '0;
    ed_d      = '0;
    wadr_d    = '0;
    we_d      = 1'b0;
    memread_d = 1'b0;
    op_d      = '0;
    if (!flush && !stall) begin
      valid_d   = in_valid;
      rdata1_d  = w_rdata1;
      rdata2_d  = w_rdata2;
      ed_d      = w_ed;
      wadr_d    = w_dest;
      we_d      = w_we;
      memread_d = w_memread;
      op_d      = w_op;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q   <= 1'b0;
      rdata1_q  <= '0;
      rdata2_q  <= '0;
      ed_q      <= '0;
      wadr_q    <= '0;
      we_q      <= 1'b0;
      memread_q <= 1'b0;
      op_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      rdata1_q  <= rdata1_d;
      rdata2_q  <= rdata2_d;
      ed_q      <= ed_d;
      wadr_q    <= wadr_d;
      we_q      <= we_d;
      memread_q <= memread_d;
      op_q      <= op_d;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (w_wb_ok) begin
      regs_q[wb_adr] <= wb_data;
    end
  end

  assign out_valid   = valid_q;
  assign out_rdata1  = rdata1_q;
  assign out_rdata2  = rdata2_q;
  assign out_ed      = ed_q;
  assign out_wadr    = wadr_q;
  assign out_we      = we_q;
  assign out_memread = memread_q;
  assign out_op      = op_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_id_stage
// Purpose  : Self-checking bench for pipe_id_stage (32-bit and 16-bit/8-reg).
// Revision : 1.0
// ============================================================================

module tb_pipe_id_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;

  logic        in_valid = 1'b0;
  logic [31:0] Ins      = '0;
  logic        flush    = 1'b0;
  logic        wb_we    = 1'b0;
  logic [4:0]  wb_adr   = '0;
  logic [31:0] wb_data  = '0;
  logic        stall, out_valid, out_we, out_memread;
  logic [31:0] out_rdata1, out_rdata2, out_ed;
  logic [4:0]  out_wadr;
  logic [5:0]  out_op;

  logic        in_valid16 = 1'b0;
  logic [31:0] Ins16      = '0;
  logic        flush16    = 1'b0;
  logic        wb_we16    = 1'b0;
  logic [2:0]  wb_adr16   = '0;
  logic [15:0] wb_data16  = '0;
  logic        stall16, out_valid16, out_we16, out_memread16;
  logic [15:0] out_rdata1_16, out_rdata2_16, out_ed16;
  logic [2:0]  out_wadr16;
  logic [5:0]  out_op16;

  int n_pass  = 0;
  int n_total = 0;

  pipe_id_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .Ins(Ins), .flush(flush),
    .wb_we(wb_we), .wb_adr(wb_adr), .wb_data(wb_data), .stall(stall),
    .out_valid(out_valid), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .out_ed(out_ed), .out_wadr(out_wadr), .out_we(out_we),
    .out_memread(out_memread), .out_op(out_op)
  );

  pipe_id_stage #(.WIDTH(16), .NREG(8)) dut16 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid16), .Ins(Ins16), .flush(flush16),
    .wb_we(wb_we16), .wb_adr(wb_adr16), .wb_data(wb_data16), .stall(stall16),
    .out_valid(out_valid16), .out_rdata1(out_rdata1_16), .out_rdata2(out_rdata2_16),
    .out_ed(out_ed16), .out_wadr(out_wadr16), .out_we(out_we16),
    .out_memread(out_memread16), .out_op(out_op16)
  );

  always #5 CLK = ~CLK;

  logic [109:0] act32;
  logic [59:0]  act16;
  assign act32 = {out_valid, out_rdata1, out_rdata2, out_ed, out_wadr, out_we, out_memread, out_op};
  assign act16 = {out_valid16, out_rdata1_16, out_rdata2_16, out_ed16, out_wadr16,
                  out_we16, out_memread16, out_op16};

  typedef struct {
    logic         vld;
    logic [31:0]  ins;
    logic         fl;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [109:0] exp;
  } vec_t;

  logic [109:0] sb_q [$];

  function automatic logic [31:0] rt_(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000000, rs, rt, rd, 5'b00000, 6'h20};
  endfunction

  function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [109:0] pk(input logic v, input logic [31:0] r1, input logic [31:0] r2,
                                      input logic [31:0] ed, input logic [4:0] wa, input logic we,
                                      input logic mem, input logic [5:0] op);
    return {v, r1, r2, ed, wa, we, mem, op};
  endfunction

  function automatic vec_t mk(input logic vld, input logic [31:0] ins, input logic fl,
                              input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [109:0] exp);
    vec_t v;
    v.vld = vld; v.ins = ins; v.fl = fl; v.we = we; v.wa = wa; v.wd = wd; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drive one instruction, queue its expected payload, check stall before the
  // edge, then pop and compare once the ID/EX register has loaded.
  task automatic issue(input string nm, input vec_t v, input logic exp_stall);
    logic [109:0] e;
    @(negedge CLK);
    in_valid = v.vld; Ins = v.ins; flush = v.fl;
    wb_we = v.we; wb_adr = v.wa; wb_data = v.wd;
    sb_q.push_back(v.exp);
    #1;
    chk({nm, "_stall"}, 128'(stall), 128'(exp_stall));
    @(posedge CLK);
    #1;
    e = sb_q.pop_front();
    chk(nm, 128'(act32), 128'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tv [13];
    logic [31:0] acc;

    tv[0]  = mk(1'b1, rt_(5'd3, 5'd5, 5'd0), 1'b0, 1'b1, 5'd5, 32'hDEADBEEF,
                pk(1'b1, 32'hDEADBEEF, 32'h0, 32'h00001820, 5'd3, 1'b1, 1'b0, 6'h00));
    tv[1]  = mk(1'b1, rt_(5'd8, 5'd5, 5'd6), 1'b0, 1'b1, 5'd6, 32'h12345678,
                pk(1'b1, 32'hDEADBEEF, 32'h12345678, 32'h00004020, 5'd8, 1'b1, 1'b0, 6'h00));
    tv[2]  = mk(1'b1, it_(6'h0D, 5'd6, 5'd9, 16'h8001), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h12345678, 32'h0, 32'h00008001, 5'd9, 1'b1, 1'b0, 6'h0D));
    tv[3]  = mk(1'b1, it_(6'h08, 5'd0, 5'd10, 16'h8001), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h0, 32'h0, 32'hFFFF8001, 5'd10, 1'b1, 1'b0, 6'h08));
    tv[4]  = mk(1'b1, rt_(5'd1, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF,
                pk(1'b1, 32'h0, 32'h0, 32'h00000820, 5'd1, 1'b1, 1'b0, 6'h00));
    tv[5]  = mk(1'b1, it_(6'h04, 5'd5, 5'd6, 16'h0004), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'hDEADBEEF, 32'h12345678, 32'h00000004, 5'd6, 1'b0, 1'b0, 6'h04));
    tv[6]  = mk(1'b1, it_(6'h2B, 5'd5, 5'd6, 16'hFFFC), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'hDEADBEEF, 32'h12345678, 32'hFFFFFFFC, 5'd6, 1'b0, 1'b0, 6'h2B));
    tv[7]  = mk(1'b1, it_(6'h03, 5'd0, 5'd0, 16'h0000), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h0, 32'h0, 32'h0, 5'd31, 1'b1, 1'b0, 6'h03));
    tv[8]  = mk(1'b1, it_(6'h23, 5'd6, 5'd0, 16'h0010), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h12345678, 32'h0, 32'h00000010, 5'd0, 1'b0, 1'b1, 6'h23));
    tv[9]  = mk(1'b1, it_(6'h0C, 5'd0, 5'd11, 16'hFFFF), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h0, 32'h0, 32'h0000FFFF, 5'd11, 1'b1, 1'b0, 6'h0C));
    tv[10] = mk(1'b1, rt_(5'd3, 5'd5, 5'd6), 1'b1, 1'b0, 5'd0, 32'h0,
                pk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h00));
    tv[11] = mk(1'b1, it_(6'h0E, 5'd6, 5'd12, 16'h8000), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h12345678, 32'h0, 32'h00008000, 5'd12, 1'b1, 1'b0, 6'h0E));
    tv[12] = mk(1'b1, it_(6'h02, 5'd0, 5'd3, 16'h0000), 1'b0, 1'b0, 5'd0, 32'h0,
                pk(1'b1, 32'h0, 32'h0, 32'h0, 5'd3, 1'b0, 1'b0, 6'h02));

    // Reset behaviour: build a live stall, then assert RST between edges.
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    wb_we = 1'b1; wb_adr = 5'd7; wb_data = 32'h00001234;
    in_valid = 1'b1; Ins = it_(6'h23, 5'd0, 5'd4, 16'h0000);
    @(posedge CLK);
    #1;
    chk("pre_rst_memread", 128'(out_memread), 128'(1'b1));
    @(negedge CLK);
    wb_we = 1'b0; Ins = rt_(5'd7, 5'd4, 5'd5);
    #1;
    chk("pre_rst_stall", 128'(stall), 128'(1'b1));
    #1;
    RST = 1'b1;
    #1;
    chk("rst_stall_drop", 128'(stall), 128'(1'b0));
    chk("rst_outs", 128'(act32), 128'(0));
    acc = '0;
    for (int i = 1; i < 32; i++) acc = acc | dut.regs_q[i];
    chk("rst_regs", 128'(acc), 128'(0));
    chk("rst_outs16", 128'(act16), 128'(0));
    @(negedge CLK);
    chk("rst_hold_outs", 128'(act32), 128'(0));
    RST = 1'b0; in_valid = 1'b0; Ins = '0;

    for (int i = 0; i < 13; i++) issue($sformatf("vec%0d", i), tv[i], 1'b0);

    // Load-use: one bubble, then the dependent add issues.
    issue("lu_lw", mk(1'b1, it_(6'h23, 5'd0, 5'd4, 16'h0000), 1'b0, 1'b0, 5'd0, 32'h0,
          pk(1'b1, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 6'h23)), 1'b0);
    issue("lu_bubble", mk(1'b1, rt_(5'd7, 5'd4, 5'd5), 1'b0, 1'b0, 5'd0, 32'h0,
          pk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h00)), 1'b1);
    issue("lu_add", mk(1'b1, rt_(5'd7, 5'd4, 5'd5), 1'b0, 1'b0, 5'd0, 32'h0,
          pk(1'b1, 32'h0, 32'hDEADBEEF, 32'h00003820, 5'd7, 1'b1, 1'b0, 6'h00)), 1'b0);

    // Flush during the stall cycle: bubble, and the killed add never reappears.
    issue("fl_lw", mk(1'b1, it_(6'h23, 5'd0, 5'd4, 16'h0000), 1'b0, 1'b0, 5'd0, 32'h0,
          pk(1'b1, 32'h0, 32'h0, 32'h0, 5'd4, 1'b1, 1'b1, 6'h23)), 1'b0);
    issue("fl_bubble", mk(1'b1, rt_(5'd7, 5'd4, 5'd5), 1'b1, 1'b0, 5'd0, 32'h0,
          pk(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h00)), 1'b1);
    issue("fl_next", mk(1'b1, it_(6'h0D, 5'd0, 5'd13, 16'h0001), 1'b0, 1'b0, 5'd0, 32'h0,
          pk(1'b1, 32'h0, 32'h0, 32'h00000001, 5'd13, 1'b1, 1'b0, 6'h0D)), 1'b0);
    issue("r0_wb", mk(1'b1, rt_(5'd2, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 32'hAAAAAAAA,
          pk(1'b1, 32'h0, 32'h0, 32'h00001020, 5'd2, 1'b1, 1'b0, 6'h00)), 1'b0);
    chk("r0_reg", 128'(dut.regs_q[0]), 128'(0));

    @(negedge CLK);
    in_valid = 1'b0; wb_we = 1'b0; Ins = '0;

    // Narrow configuration: jal targets r7, register fields truncate to 3 bits.
    in_valid16 = 1'b1; Ins16 = it_(6'h03, 5'd0, 5'd0, 16'h0000);
    @(posedge CLK);
    #1;
    chk("p16_jal", 128'({out_valid16, out_wadr16, out_we16}), 128'({1'b1, 3'd7, 1'b1}));
    @(negedge CLK);
    wb_we16 = 1'b1; wb_adr16 = 3'd5; wb_data16 = 16'hBEEF;
    Ins16 = it_(6'h08, 5'd13, 5'd2, 16'h8000);
    @(posedge CLK);
    #1;
    chk("p16_addi", 128'(act16),
        128'({1'b1, 16'hBEEF, 16'h0000, 16'h8000, 3'd2, 1'b1, 1'b0, 6'h08}));
    @(negedge CLK);
    in_valid16 = 1'b0; wb_we16 = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
